// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: command sequencer for the 8-bit MAC datapath.
// Takes a (len, mode) command, streams len operand pairs over a
// valid/ready handshake, accumulates e1*opB and reports the sum.
//
// Parameters:
//   ACC_W     accumulator / result width, 16..32
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, len, mode    command strobe, beat count, opB select
//   abort               cancel a running command
//   in_valid/in_ready   operand pair handshake
//   e1, e2              operand A, alternate operand B
//   select              operand mux select (latched mode while busy)
//   busy, done          command in progress, one-cycle completion pulse
//   result, ovf         final sum and sticky overflow flag
// Build option:
//   MAC_SAT_EN          saturate the accumulator on overflow instead
//                       of wrapping
module mac_seq_ctrl #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       len,
    input  logic             mode,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       e1,
    input  logic [7:0]       e2,
    output logic             select,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] result,
    output logic             ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic             mode_q;
    logic [7:0]       opb;
    logic [15:0]      prod;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             beat;
    logic             last;

    assign opb   = mode_q ? e2 : e1;
    assign prod  = e1 * opb;
    assign sum   = {1'b0, acc} + (ACC_W+1)'(prod);
    assign carry = sum[ACC_W];

    // abort wins over a presented beat: the pair is not taken
    assign beat = (state == S_RUN) && in_valid && !abort;
    assign last = beat && (cnt == 8'd1);

    always_comb begin
        acc_nxt = sum[ACC_W-1:0];
`ifdef MAC_SAT_EN
        // once overflowed, the accumulator stays pinned at full scale
        if (carry || ovf)
            acc_nxt = '1;
`else
        acc_nxt = sum[ACC_W-1:0];
`endif
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start)
                    state_nxt = (len == 8'd0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (abort)
                    state_nxt = S_IDLE;
                else if (last)
                    state_nxt = S_DONE;
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // output logic
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        select   = 1'b0;
        unique case (state)
            S_IDLE: ;
            S_RUN: begin
                in_ready = !abort;
                busy     = 1'b1;
                select   = mode_q;
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                select = mode_q;
            end
            default: ;
        endcase
    end

    // datapath: result is loaded with the final sum as the last beat
    // lands, so it is already valid while done is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
            cnt    <= 8'd0;
            acc    <= '0;
            result <= '0;
            ovf    <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                mode_q <= mode;
                cnt    <= len;
                acc    <= '0;
                ovf    <= 1'b0;
                if (len == 8'd0)
                    result <= '0;
            end else if (beat) begin
                acc <= acc_nxt;
                cnt <= cnt - 8'd1;
                ovf <= ovf | carry;
                if (last)
                    result <= acc_nxt;
            end
        end
    end

endmodule
